// File: rtl/video_timing_pkg.sv
// Shared types and default 640x480@60 timing for the raster timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PhActive = 2'd0,
    PhFp     = 2'd1,
    PhSync   = 2'd2,
    PhBp     = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Keeps vector widths legal when a dimension is 1 or 2.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing-generator output bundle: run request in, sync/de/coordinates/markers out.
interface video_timing_gen_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9
);
  logic               enable;
  logic               busy;
  logic               out_vsync;
  logic               out_hsync;
  logic               out_de;
  logic [X_WIDTH-1:0] out_x;
  logic [Y_WIDTH-1:0] out_y;
  logic               out_fs;
  logic               out_le;

  modport master (
    input  enable,
    output busy, out_vsync, out_hsync, out_de, out_x, out_y, out_fs, out_le
  );

  modport slave (
    output enable,
    input  busy, out_vsync, out_hsync, out_de, out_x, out_y, out_fs, out_le
  );
endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping counter plus ACTIVE/FP/SYNC/BP phase decode.
// cnt/phase describe the count the axis will hold after the coming clock edge.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE    = DEF_H_ACTIVE,
  parameter int FP        = DEF_H_FP,
  parameter int SYNC      = DEF_H_SYNC,
  parameter int BP        = DEF_H_BP,
  parameter int CNT_WIDTH = clog2_min1(ACTIVE + FP + SYNC + BP)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] cnt,
  output phase_t               phase,
  output logic                 wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] END_ACT = CNT_WIDTH'(ACTIVE);
  localparam logic [CNT_WIDTH-1:0] END_FP  = CNT_WIDTH'(ACTIVE + FP);
  localparam logic [CNT_WIDTH-1:0] END_SYN = CNT_WIDTH'(ACTIVE + FP + SYNC);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_d;

  assign wrap = step && (r_cnt == LAST);

  always_comb begin
    w_cnt_d = r_cnt;
    if (clear || wrap) begin
      w_cnt_d = '0;
    end else if (step) begin
      w_cnt_d = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    if (w_cnt_d < END_ACT) begin
      phase = PhActive;
    end else if (w_cnt_d < END_FP) begin
      phase = PhFp;
    end else if (w_cnt_d < END_SYN) begin
      phase = PhSync;
    end else begin
      phase = PhBp;
    end
  end

  assign cnt = w_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: IDLE/RUN control, H/V axes and a registered
// output stage producing sync, de, coordinates and frame-start/line-end markers.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int X_WIDTH   = clog2_min1(H_ACTIVE),
  parameter int Y_WIDTH   = clog2_min1(V_ACTIVE)
) (
  input  logic               clk,
  input  logic               reset_n,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = clog2_min1(H_TOTAL);
  localparam int VW      = clog2_min1(V_TOTAL);
  localparam logic [HW-1:0] H_LAST_ACT = HW'(H_ACTIVE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("video_timing_gen: every timing parameter must be at least 1");
  end

  logic [0:0]         r_state;
  logic [0:0]         w_state_d;
  logic [HW-1:0]      w_h_cnt;
  logic [VW-1:0]      w_v_cnt;
  phase_t             w_h_phase;
  phase_t             w_v_phase;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_run_d;
  logic               w_de_d;
  logic               r_vsync;
  logic               r_hsync;
  logic               r_de;
  logic               r_fs;
  logic               r_le;
  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;

  video_timing_axis #(
    .ACTIVE    (H_ACTIVE),
    .FP        (H_FP),
    .SYNC      (H_SYNC),
    .BP        (H_BP),
    .CNT_WIDTH (HW)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (r_state == ST_RUN),
    .clear   (r_state == ST_IDLE),
    .cnt     (w_h_cnt),
    .phase   (w_h_phase),
    .wrap    (w_h_wrap)
  );

  video_timing_axis #(
    .ACTIVE    (V_ACTIVE),
    .FP        (V_FP),
    .SYNC      (V_SYNC),
    .BP        (V_BP),
    .CNT_WIDTH (VW)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (w_h_wrap),
    .clear   (r_state == ST_IDLE),
    .cnt     (w_v_cnt),
    .phase   (w_v_phase),
    .wrap    (w_v_wrap)
  );

  // enable only matters in IDLE or on the last clock of a frame.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (vif.enable) w_state_d = ST_RUN;
      ST_RUN:  if (w_v_wrap && !vif.enable) w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign w_run_d = (w_state_d == ST_RUN);
  assign w_de_d  = w_run_d && (w_h_phase == PhActive) && (w_v_phase == PhActive);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_vsync <= ~VSYNC_POL;
      r_hsync <= ~HSYNC_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_le    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_d;
      r_vsync <= (w_run_d && (w_v_phase == PhSync)) ? VSYNC_POL : ~VSYNC_POL;
      r_hsync <= (w_run_d && (w_h_phase == PhSync)) ? HSYNC_POL : ~HSYNC_POL;
      r_de    <= w_de_d;
      r_fs    <= w_de_d && (w_h_cnt == '0) && (w_v_cnt == '0);
      r_le    <= w_de_d && (w_h_cnt == H_LAST_ACT);
      r_x     <= w_de_d ? X_WIDTH'(w_h_cnt) : '0;
      r_y     <= w_de_d ? Y_WIDTH'(w_v_cnt) : '0;
    end
  end

  assign vif.busy      = (r_state == ST_RUN);
  assign vif.out_vsync = r_vsync;
  assign vif.out_hsync = r_hsync;
  assign vif.out_de    = r_de;
  assign vif.out_fs    = r_fs;
  assign vif.out_le    = r_le;
  assign vif.out_x     = r_x;
  assign vif.out_y     = r_y;

endmodule

// File: tb/tb_video_timing_gen.sv
// Three generator configurations on one clock/reset/enable, checked every cycle
// against a behavioural raster model plus hand-derived checkpoints on the 640-wide one.
module tb_video_timing_gen;

  typedef struct packed {
    logic        busy;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic        fs;
    logic        le;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  typedef struct {
    int   ha, hf, hw, hb, va, vf, vw, vb;
    logic hpol, vpol;
  } mode_t;

  typedef struct {
    logic run;
    int   h;
    int   v;
  } mstate_t;

  typedef struct {
    int   adv;
    logic en;
    obs_t exp;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  mode_t   mode [3];
  mstate_t mst  [3];
  obs_t    sb_q [$];
  vec_t    vtab [$];

  always #5 clk = ~clk;

  // A: full-width lines, short frame. B: tiny, positive syncs. C: tiny lines, full-height frame.
  video_timing_gen_if #(.X_WIDTH(10), .Y_WIDTH(2)) if_a ();
  video_timing_gen_if #(.X_WIDTH(2),  .Y_WIDTH(2)) if_b ();
  video_timing_gen_if #(.X_WIDTH(2),  .Y_WIDTH(9)) if_c ();

  video_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4),   .V_FP(1),  .V_SYNC(2),  .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .X_WIDTH(10), .Y_WIDTH(2)
  ) u_dut_a (.clk(clk), .reset_n(reset_n), .vif(if_a));

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .X_WIDTH(2), .Y_WIDTH(2)
  ) u_dut_b (.clk(clk), .reset_n(reset_n), .vif(if_b));

  video_timing_gen #(
    .H_ACTIVE(4),   .H_FP(1),  .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .X_WIDTH(2), .Y_WIDTH(9)
  ) u_dut_c (.clk(clk), .reset_n(reset_n), .vif(if_c));

  obs_t act_a, act_b, act_c;
  assign act_a = {if_a.busy, if_a.out_vsync, if_a.out_hsync, if_a.out_de, if_a.out_fs,
                  if_a.out_le, 16'(if_a.out_x), 16'(if_a.out_y)};
  assign act_b = {if_b.busy, if_b.out_vsync, if_b.out_hsync, if_b.out_de, if_b.out_fs,
                  if_b.out_le, 16'(if_b.out_x), 16'(if_b.out_y)};
  assign act_c = {if_c.busy, if_c.out_vsync, if_c.out_hsync, if_c.out_de, if_c.out_fs,
                  if_c.out_le, 16'(if_c.out_x), 16'(if_c.out_y)};

  function automatic obs_t actual(input int d);
    case (d)
      0:       return act_a;
      1:       return act_b;
      default: return act_c;
    endcase
  endfunction

  function automatic obs_t mk(input logic busy, vs, hs, de, fs, le, input int x, y);
    obs_t o;
    o = {busy, vs, hs, de, fs, le, 16'(x), 16'(y)};
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0b vs=%0b hs=%0b de=%0b fs=%0b le=%0b x=%0d y=%0d",
                     o.busy, o.vsync, o.hsync, o.de, o.fs, o.le, o.x, o.y);
  endfunction

  // State after a clock edge: position of the pixel presented on the outputs.
  function automatic mstate_t model_step(input mode_t m, input mstate_t s, input logic en);
    mstate_t n;
    int ht, vt;
    n  = s;
    ht = m.ha + m.hf + m.hw + m.hb;
    vt = m.va + m.vf + m.vw + m.vb;
    if (!s.run) begin
      if (en) begin
        n.run = 1'b1; n.h = 0; n.v = 0;
      end
    end else if (s.h == ht - 1) begin
      n.h = 0;
      if (s.v == vt - 1) begin
        n.v   = 0;
        n.run = en;
      end else begin
        n.v = s.v + 1;
      end
    end else begin
      n.h = s.h + 1;
    end
    return n;
  endfunction

  function automatic obs_t model_out(input mode_t m, input mstate_t s);
    obs_t o;
    o       = '0;
    o.hsync = ~m.hpol;
    o.vsync = ~m.vpol;
    if (s.run) begin
      o.busy = 1'b1;
      o.de   = (s.h < m.ha) && (s.v < m.va);
      if (s.h >= m.ha + m.hf && s.h < m.ha + m.hf + m.hw) o.hsync = m.hpol;
      if (s.v >= m.va + m.vf && s.v < m.va + m.vf + m.vw) o.vsync = m.vpol;
      if (o.de) begin
        o.x  = 16'(s.h);
        o.y  = 16'(s.v);
        o.fs = (s.h == 0) && (s.v == 0);
        o.le = (s.h == m.ha - 1);
      end
    end
    return o;
  endfunction

  task automatic check_vec(input string name, input int d, input obs_t exp);
    obs_t act;
    act = actual(d);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %s, expected %s", name, d, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_sb(input string name);
    for (int d = 0; d < 3; d++) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s dut%0d: scoreboard empty, expected an entry", name, d);
      end else begin
        check_vec(name, d, sb_q.pop_front());
      end
    end
  endtask

  task automatic set_enable(input logic en);
    if_a.enable = en;
    if_b.enable = en;
    if_c.enable = en;
  endtask

  // Called at a falling edge: drive, predict, clock, compare.
  task automatic tick(input logic en);
    set_enable(en);
    for (int d = 0; d < 3; d++) begin
      if (!reset_n) mst[d] = '{run: 1'b0, h: 0, v: 0};
      else          mst[d] = model_step(mode[d], mst[d], en);
      sb_q.push_back(model_out(mode[d], mst[d]));
    end
    @(posedge clk);
    #1;
    check_sb("cycle");
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string name);
    for (int d = 0; d < 3; d++) begin
      mst[d] = '{run: 1'b0, h: 0, v: 0};
      sb_q.push_back(model_out(mode[d], mst[d]));
    end
    check_sb(name);
  endtask

  initial begin
    obs_t idle_a, pix00_a;
    idle_a  = mk(0, 1, 1, 0, 0, 0, 0, 0);
    pix00_a = mk(1, 1, 1, 1, 1, 0, 0, 0);

    mode[0] = '{ha: 640, hf: 16, hw: 96, hb: 48, va: 4, vf: 1, vw: 2, vb: 1,
                hpol: 1'b0, vpol: 1'b0};
    mode[1] = '{ha: 4, hf: 1, hw: 2, hb: 1, va: 3, vf: 1, vw: 1, vb: 1,
                hpol: 1'b1, vpol: 1'b1};
    mode[2] = '{ha: 4, hf: 1, hw: 2, hb: 1, va: 480, vf: 10, vw: 2, vb: 33,
                hpol: 1'b0, vpol: 1'b0};

    // Hand-derived checkpoints on dut0 (800-clock lines, 8-line frame), cumulative
    // clocks since enable: 1,2,640,641,657,752,753,801,3040,3201,4001,4657,5601,6401,...
    vtab.push_back('{adv: 1,    en: 1'b1, exp: pix00_a});
    vtab.push_back('{adv: 1,    en: 1'b1, exp: mk(1, 1, 1, 1, 0, 0, 1, 0)});
    vtab.push_back('{adv: 638,  en: 1'b1, exp: mk(1, 1, 1, 1, 0, 1, 639, 0)});
    vtab.push_back('{adv: 1,    en: 1'b1, exp: mk(1, 1, 1, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 16,   en: 1'b1, exp: mk(1, 1, 0, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 95,   en: 1'b1, exp: mk(1, 1, 0, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 1,    en: 1'b1, exp: mk(1, 1, 1, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 48,   en: 1'b1, exp: mk(1, 1, 1, 1, 0, 0, 0, 1)});
    vtab.push_back('{adv: 2239, en: 1'b1, exp: mk(1, 1, 1, 1, 0, 1, 639, 3)});
    vtab.push_back('{adv: 161,  en: 1'b1, exp: mk(1, 1, 1, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 800,  en: 1'b1, exp: mk(1, 0, 1, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 656,  en: 1'b1, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 944,  en: 1'b1, exp: mk(1, 1, 1, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 800,  en: 1'b1, exp: pix00_a});
    vtab.push_back('{adv: 6399, en: 1'b0, exp: mk(1, 1, 1, 0, 0, 0, 0, 0)});
    vtab.push_back('{adv: 1,    en: 1'b0, exp: idle_a});
    vtab.push_back('{adv: 50,   en: 1'b0, exp: idle_a});
    vtab.push_back('{adv: 1,    en: 1'b1, exp: pix00_a});

    set_enable(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    async_reset_check("reset_assert");

    @(negedge clk);
    tick(1'b0);
    tick(1'b0);
    reset_n = 1'b1;

    foreach (vtab[i]) begin
      repeat (vtab[i].adv) tick(vtab[i].en);
      check_vec($sformatf("table[%0d]", i), 0, vtab[i].exp);
    end

    // Reset mid-line with no clock edge following.
    repeat (100) tick(1'b1);
    check_vec("pre_reset_x", 0, mk(1, 1, 1, 1, 0, 0, 100, 0));
    #2;
    reset_n = 1'b0;
    #1;
    async_reset_check("reset_mid_line");
    @(negedge clk);
    tick(1'b1);
    tick(1'b1);
    reset_n = 1'b1;

    // One-clock enable pulse: each configuration runs exactly one frame, then idles.
    tick(1'b1);
    check_vec("restart_fs", 0, pix00_a);
    repeat (6399) tick(1'b0);
    check_vec("pulse_last_clock", 0, mk(1, 1, 1, 0, 0, 0, 0, 0));
    tick(1'b0);
    check_vec("pulse_stop", 0, idle_a);
    repeat (20) tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
